instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have the ports clk (input, 1: rising-edge clock) and reset (input, 1: synchronous, active-high reset).
REQ-002 The module SHALL have current_pc (input, 32) driven from the program counter, which loads 0 on reset, setAddress when PCSrc=1, and PC+4 otherwise.
REQ-003 The module SHALL have PCSrc (output, 1) and setAddress (output, 32), which together form the redirect request to the program counter.
REQ-004 The module SHALL have imem_addr (output, 32) and imem_rdata (input, 32) for a synchronous instruction memory whose data returns 1 cycle after the address.
REQ-005 The module SHALL have the redirect_valid (input, 1) and redirect_addr (input, 32) ports, through which execute reports a taken branch.
REQ-006 The module SHALL have the decode-side ports instr_valid (output, 1), instr_ready (input, 1), instr_out (output, 32) and instr_pc (output, 32).
REQ-007 The module SHALL have fifo_count (output, 3), which gives the fetch buffer occupancy from 0 to 4.

Function
REQ-008 imem_addr SHALL equal current_pc combinationally.
REQ-009 The request stage SHALL register req_valid and req_pc<=current_pc every cycle, where req_valid=1 unless the request is squashed.
REQ-010 The response stage SHALL see imem_rdata as the word at req_pc, and SHALL push {req_pc, imem_rdata} into the 4-entry FIFO when req_valid=1 and a slot is free.
REQ-011 A slot SHALL be free when count<4, or when count=4 and a pop occurs in the same cycle.
REQ-012 A pop SHALL occur when instr_valid && instr_ready; instr_valid SHALL be count!=0, and instr_out/instr_pc SHALL come from the FIFO head.
REQ-013 The FIFO read and write pointers SHALL be 2 bits and SHALL wrap from 3 to 0; simultaneous push and pop SHALL leave count unchanged.
REQ-014 The redirect sources SHALL be prioritised highest first, and PCSrc/setAddress SHALL be combinational:
  - (a) external: redirect_valid=1 -> setAddress=redirect_addr;
  - (b) replay: req_valid=1 and no free slot -> setAddress=req_pc;
  - (c) jump, when enabled (REQ-021).
REQ-015 An external redirect SHALL flush the FIFO (count->0 next cycle), SHALL drop the same-cycle push, and SHALL discard the same-cycle pop.
REQ-016 Any redirect asserted in cycle t SHALL clear req_valid for the request captured at the end of cycle t, i.e. the wrong-path fetch.
REQ-017 A replay SHALL leave the FIFO contents intact; if the buffer is still full when the replayed fetch returns, the replay SHALL repeat indefinitely.
REQ-018 The block SHALL never drop or duplicate an instruction in program order except on an external redirect.
REQ-019 Redirect latency SHALL be as follows: with PCSrc=1 at cycle t, the first target instruction SHALL become pushable at t+2.

Reset
REQ-020 While reset=1 the outputs SHALL be:
  - count=0, pointers=0, req_valid=0;
  - instr_valid=0, PCSrc=0, setAddress=0, fifo_count=0;
  - the first request SHALL be captured at the first edge after reset falls, and reset mid-operation SHALL discard all buffered and in-flight instructions.

Configuration
REQ-021 With FETCH_JUMP_PREDICT_EN defined, an instruction being pushed with opcode imem_rdata[31:26]=6'b000010 SHALL be pushed and SHALL assert PCSrc with setAddress={req_pc+4[31:28], imem_rdata[25:0], 2'b00} (priority c).
REQ-022 Without FETCH_JUMP_PREDICT_EN, J instructions SHALL be pushed as ordinary instructions and only redirect sources (a) and (b) SHALL exist.

Verification
REQ-023 After reset, with instr_ready=1 and memory word=address, the bench SHALL see instr_pc 0,4,8,... delivered one per cycle, with the first instr_valid 2 cycles after reset falls.
REQ-024 With instr_ready=0 the bench SHALL see fifo_count rise to 4, then PCSrc=1 with setAddress=16, and repeated replays of 16; after raising instr_ready, instr_pc SHALL continue 0,4,8,12,16,20 with no gap or duplicate.
REQ-025 When redirect_valid=1 with redirect_addr=0x40 is applied while count=3, the bench SHALL see PCSrc=1 and setAddress=0x40, count 0 the next cycle, and the next instr_pc=0x40.
REQ-026 When redirect_valid and replay conditions coincide, the bench SHALL see setAddress equal to redirect_addr.
REQ-027 With FETCH_JUMP_PREDICT_EN defined, when the memory at 0x8 holds 0x08000010, the bench SHALL see PCSrc=1 with setAddress=0x40, the instruction at 0xC squashed, and the next instr_pc=0x40; without the macro, the bench SHALL see 0xC follow.
REQ-028 When reset is pulsed while fifo_count=3, the bench SHALL see instr_valid=0 the next cycle and a restart at instr_pc=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: PC redirect request, instruction memory port, execute redirect and decode handshake.
// The master modport is the fetch unit; the slave modport is its surrounding pipeline.
interface instruction_fetch_if;
   logic [31:0] current_pc;
   logic        PCSrc;
   logic [31:0] setAddress;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic [2:0]  fifo_count;

   modport master (
      input  current_pc, imem_rdata, redirect_valid, redirect_addr, instr_ready,
      output PCSrc, setAddress, imem_addr, instr_valid, instr_out, instr_pc, fifo_count
   );

   modport slave (
      output current_pc, imem_rdata, redirect_valid, redirect_addr, instr_ready,
      input  PCSrc, setAddress, imem_addr, instr_valid, instr_out, instr_pc, fifo_count
   );
endinterface

// File: rtl/instruction_fetch.sv
// Two-stage instruction fetch (request, response) feeding a 4-entry buffer, with replay on a full buffer.
// Define FETCH_JUMP_PREDICT_EN to redirect on J-type opcodes as they enter the buffer.
module instruction_fetch (
   input  logic                      clk,
   input  logic                      reset,
   instruction_fetch_if.master       bus
);
   localparam logic [5:0] J_OPCODE = 6'b000010;

   logic        req_valid_q, req_valid_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [2:0]  count_q, count_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0] fifo_pc_q    [4];
   logic [31:0] fifo_instr_q [4];

   logic        ext_redirect;
   logic        head_valid;
   logic        pop;
   logic        slot_free;
   logic        push;
   logic        replay;
   logic        jump_take;
   logic [31:0] jump_target;
   logic        pc_src;
   logic [31:0] set_addr;

`ifdef FETCH_JUMP_PREDICT_EN
   logic [31:0] req_pc_plus4;
   assign req_pc_plus4 = req_pc_q + 32'd4;
`endif

   always_comb begin
      ext_redirect = bus.redirect_valid && !reset;
      head_valid   = (count_q != 3'd0) && !reset;
      // A redirect from execute cancels whatever decode would have taken this cycle.
      pop          = head_valid && bus.instr_ready && !ext_redirect;
      slot_free    = (count_q < 3'd4) || ((count_q == 3'd4) && pop);
      push         = req_valid_q && slot_free && !ext_redirect && !reset;
      replay       = req_valid_q && !slot_free && !reset;
`ifdef FETCH_JUMP_PREDICT_EN
      jump_take    = push && (bus.imem_rdata[31:26] == J_OPCODE);
      jump_target  = {req_pc_plus4[31:28], bus.imem_rdata[25:0], 2'b00};
`else
      jump_take    = 1'b0;
      jump_target  = 32'd0;
`endif

      pc_src   = 1'b0;
      set_addr = 32'd0;
      if (ext_redirect) begin
         pc_src   = 1'b1;
         set_addr = bus.redirect_addr;
      end else if (replay) begin
         pc_src   = 1'b1;
         set_addr = req_pc_q;
      end else if (jump_take) begin
         pc_src   = 1'b1;
         set_addr = jump_target;
      end
   end

   always_comb begin
      // The fetch already issued while redirecting is wrong-path and gets squashed.
      req_valid_d = !pc_src;
      req_pc_d    = bus.current_pc;
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (ext_redirect) begin
         count_d  = 3'd0;
         wr_ptr_d = 2'd0;
         rd_ptr_d = 2'd0;
      end else begin
         count_d  = count_q + {2'b00, push} - {2'b00, pop};
         wr_ptr_d = wr_ptr_q + {1'b0, push};
         rd_ptr_d = rd_ptr_q + {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_valid_q <= 1'b0;
         req_pc_q    <= 32'd0;
         count_q     <= 3'd0;
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
      end else begin
         req_valid_q <= req_valid_d;
         req_pc_q    <= req_pc_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]    <= req_pc_q;
         fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

   assign bus.imem_addr   = bus.current_pc;
   assign bus.PCSrc       = pc_src;
   assign bus.setAddress  = set_addr;
   assign bus.instr_valid = head_valid;
   assign bus.instr_out   = fifo_instr_q[rd_ptr_q];
   assign bus.instr_pc    = fifo_pc_q[rd_ptr_q];
   assign bus.fifo_count  = reset ? 3'd0 : count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: models the PC register and a 1-cycle instruction memory,
// queues expected instr_pc values per scenario and checks deliveries in a separate monitor.
module tb_instruction_fetch;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic jump_word = 1'b0;
   int   total = 0;
   int   passed = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   logic        pcsrc_seen;
   logic [31:0] pcsrc_addr;

   always #5 clk = ~clk;

   instruction_fetch_if bus();

   instruction_fetch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (jump_word && a == 32'h8) ? 32'h0800_0010 : a;
   endfunction

   always @(posedge clk) begin
      if (reset)          bus.current_pc <= 32'd0;
      else if (bus.PCSrc) bus.current_pc <= bus.setAddress;
      else                bus.current_pc <= bus.current_pc + 32'd4;
      bus.imem_rdata <= memw(bus.imem_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (!reset && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_instr: got pc %h with nothing expected at %0t", bus.instr_pc, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("instr_pc", bus.instr_pc, mon_exp);
            chk("instr_out", bus.instr_out, memw(mon_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = 32'd0;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic wait_count(input logic [2:0] n);
      for (int i = 0; i < 40 && bus.fifo_count != n; i++) tick();
      chk("reach_fifo_count", {29'd0, bus.fifo_count}, {29'd0, n});
   endtask

   task automatic drain(input string name);
      pcsrc_seen = 1'b0;
      pcsrc_addr = 32'd0;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         tick();
         if (bus.PCSrc && !pcsrc_seen) begin
            pcsrc_seen = 1'b1;
            pcsrc_addr = bus.setAddress;
         end
      end
      chk(name, exp_q.size(), 0);
      exp_q.delete();
      bus.instr_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_replay;
      int bad_replay;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h0000_0100;
      // Sequential stream with a redirect held during reset: outputs must stay quiet.
      tick();
      chk("rst_instr_valid", {31'd0, bus.instr_valid}, 0);
      chk("rst_PCSrc", {31'd0, bus.PCSrc}, 0);
      chk("rst_setAddress", bus.setAddress, 0);
      chk("rst_fifo_count", {29'd0, bus.fifo_count}, 0);
      tick();
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      reset = 1'b0;
      tick();
      chk("first_valid_t1", {31'd0, bus.instr_valid}, 0);
      tick();
      chk("first_valid_t2", {31'd0, bus.instr_valid}, 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("stream_no_gap", {31'd0, bus.instr_valid}, 1);
      end
      drain("seq_drain");

      // Backpressure: fill, replay 16 repeatedly, then resume in order.
      do_reset();
      wait_count(3'd4);
      chk("replay_PCSrc", {31'd0, bus.PCSrc}, 1);
      chk("replay_setAddress", bus.setAddress, 32'd16);
      n_replay = 0;
      bad_replay = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.PCSrc) begin
            n_replay++;
            if (bus.setAddress != 32'd16) bad_replay++;
         end
      end
      chk("replay_addr_stable", bad_replay, 0);
      chk("replay_repeats", {31'd0, n_replay >= 3}, 1);
      chk("full_count_held", {29'd0, bus.fifo_count}, 4);
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
      bus.instr_ready = 1'b1;
      drain("replay_drain");

      // External redirect while three entries are buffered.
      do_reset();
      wait_count(3'd3);
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h40;
      #1;
      chk("ext_PCSrc", {31'd0, bus.PCSrc}, 1);
      chk("ext_setAddress", bus.setAddress, 32'h40);
      tick();
      bus.redirect_valid = 1'b0;
      chk("ext_flush_count", {29'd0, bus.fifo_count}, 0);
      exp_q.push_back(32'h40);
      exp_q.push_back(32'h44);
      exp_q.push_back(32'h48);
      bus.instr_ready = 1'b1;
      drain("ext_drain");

      // External redirect beats a replay in the same cycle.
      do_reset();
      wait_count(3'd4);
      chk("prio_replay_present", {31'd0, bus.PCSrc}, 1);
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h80;
      #1;
      chk("prio_PCSrc", {31'd0, bus.PCSrc}, 1);
      chk("prio_setAddress", bus.setAddress, 32'h80);
      tick();
      bus.redirect_valid = 1'b0;
      chk("prio_flush_count", {29'd0, bus.fifo_count}, 0);
      exp_q.push_back(32'h80);
      exp_q.push_back(32'h84);
      bus.instr_ready = 1'b1;
      drain("prio_drain");

      // J instruction at 0x8 targeting 0x40.
      jump_word = 1'b1;
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
`ifdef FETCH_JUMP_PREDICT_EN
      exp_q.push_back(32'h40);
      exp_q.push_back(32'h44);
`else
      exp_q.push_back(32'hC);
      exp_q.push_back(32'h10);
`endif
      bus.instr_ready = 1'b1;
      drain("jump_drain");
`ifdef FETCH_JUMP_PREDICT_EN
      chk("jump_PCSrc", {31'd0, pcsrc_seen}, 1);
      chk("jump_setAddress", pcsrc_addr, 32'h40);
`else
      chk("nojump_PCSrc", {31'd0, pcsrc_seen}, 0);
`endif
      jump_word = 1'b0;

      // Reset mid-stream with three buffered entries.
      do_reset();
      wait_count(3'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_instr_valid", {31'd0, bus.instr_valid}, 0);
      chk("midrst_fifo_count", {29'd0, bus.fifo_count}, 0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      bus.instr_ready = 1'b1;
      drain("midrst_drain");

      repeat (3) tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
